// File: rtl/frame_update_scheduler_pkg.sv
// Shared constants, FSM state type and clamp helper for the frame update scheduler.
// ACCEL_FILTER_EN (optional) enables accelerometer smoothing in frame_update_scheduler.
package frame_update_scheduler_pkg;

  localparam int H_RES       = 640;
  localparam int V_RES       = 480;
  localparam int PLAYER_HALF = 25;
  localparam int TARGET_HALF = 30;
  localparam int STEP        = 4;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned SCORE_W = 8;

  localparam int X_LO     = PLAYER_HALF;
  localparam int X_HI     = H_RES - 1 - PLAYER_HALF;
  localparam int Y_LO     = PLAYER_HALF;
  localparam int Y_HI     = V_RES - 1 - PLAYER_HALF;
  localparam int HIT_DIST = PLAYER_HALF + TARGET_HALF;

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StMove,
    StClamp,
    StCollide,
    StCommit
  } fsm_state_t;

  function automatic logic signed [31:0] clamp_s32(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/frame_update_scheduler_if.sv
// Game-side signal bundle of the frame update scheduler: inputs from the sources, outputs
// to the renderer. The slave modport is the scheduler's view.
interface frame_update_scheduler_if;

  logic                                         screen_end;
  logic                                         enable;
  logic                                         btn_u;
  logic                                         btn_l;
  logic                                         btn_r;
  logic                                         btn_d;
  logic [31:0]                                  accel_x;
  logic [31:0]                                  accel_y;
  logic [31:0]                                  target_x;
  logic [31:0]                                  target_y;
  logic [frame_update_scheduler_pkg::X_W-1:0]     player_x;
  logic [frame_update_scheduler_pkg::Y_W-1:0]     player_y;
  logic [frame_update_scheduler_pkg::X_W-1:0]     target_cx;
  logic [frame_update_scheduler_pkg::Y_W-1:0]     target_cy;
  logic                                         frame_valid;
  logic                                         hit;
  logic [frame_update_scheduler_pkg::SCORE_W-1:0] score;
  logic                                         busy;

  modport master (
    output screen_end, enable, btn_u, btn_l, btn_r, btn_d,
    output accel_x, accel_y, target_x, target_y,
    input  player_x, player_y, target_cx, target_cy, frame_valid, hit, score, busy
  );

  modport slave (
    input  screen_end, enable, btn_u, btn_l, btn_r, btn_d,
    input  accel_x, accel_y, target_x, target_y,
    output player_x, player_y, target_cx, target_cy, frame_valid, hit, score, busy
  );

endinterface

// File: rtl/frame_update_scheduler_coord_clamp.sv
// Limits a signed 32-bit coordinate candidate to [Lo, Hi] and returns it as a W-bit value.
module coord_clamp
  import frame_update_scheduler_pkg::*;
#(
  parameter int          Lo = 0,
  parameter int          Hi = 0,
  parameter int unsigned W  = 10
) (
  input  logic signed [31:0] val_i,
  output logic [W-1:0]       val_o
);

  always_comb begin
    val_o = W'(clamp_s32(val_i, Lo, Hi));
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame game sequencer: on each screen_end rise, moves/clamps the player, latches the
// target, scores overlaps. Optional macro ACCEL_FILTER_EN smooths accelerometer motion.
module frame_update_scheduler
  import frame_update_scheduler_pkg::*;
(
  input logic                      clk_25mHz,
  input logic                      reset_n,
  frame_update_scheduler_if.slave  bus
);

  fsm_state_t state_q, state_d;
  logic              se_q;
  logic [3:0]        btn_q;  // {d, r, l, u}
  logic signed [31:0] ax_q, ay_q;
  logic [X_W-1:0]    tx_q, cx_q, px_q, tcx_q, clamp_x;
  logic [Y_W-1:0]    ty_q, cy_q, py_q, tcy_q, clamp_y;
  logic signed [31:0] cand_x_q, cand_y_q, cand_x_d, cand_y_d;
  logic [SCORE_W-1:0] score_q;
  logic              prev_q, fv_q, hit_q;
  logic              start, overlap, new_hit;
  logic signed [11:0] bx, by;
  logic [X_W-1:0]    dx;
  logic [Y_W-1:0]    dy;
  logic              unused_tgt;

  assign unused_tgt = ^{bus.target_x[31:X_W], bus.target_y[31:Y_W]};
  assign start = bus.screen_end & ~se_q & bus.enable & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StSample;
      StSample:  state_d = StMove;
      StMove:    state_d = StClamp;
      StClamp:   state_d = StCollide;
      StCollide: state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // 12-bit signed step so a move below zero stays negative and clamps to the lower bound.
  always_comb begin
    bx = signed'({2'b00, px_q});
    by = signed'({3'b000, py_q});
    if (btn_q[1] && !btn_q[2]) bx = bx - 12'(STEP);
    if (btn_q[2] && !btn_q[1]) bx = bx + 12'(STEP);
    if (btn_q[0] && !btn_q[3]) by = by - 12'(STEP);
    if (btn_q[3] && !btn_q[0]) by = by + 12'(STEP);
    if (|btn_q) begin
      cand_x_d = {{20{bx[11]}}, bx};
      cand_y_d = {{20{by[11]}}, by};
    end else begin
`ifdef ACCEL_FILTER_EN
      cand_x_d = (signed'({22'd0, px_q}) + clamp_s32(ax_q, X_LO, X_HI)) >>> 1;
      cand_y_d = (signed'({23'd0, py_q}) + clamp_s32(ay_q, Y_LO, Y_HI)) >>> 1;
`else
      cand_x_d = ax_q;
      cand_y_d = ay_q;
`endif
    end
  end

  coord_clamp #(.Lo(X_LO), .Hi(X_HI), .W(X_W)) u_clamp_x (.val_i(cand_x_q), .val_o(clamp_x));
  coord_clamp #(.Lo(Y_LO), .Hi(Y_HI), .W(Y_W)) u_clamp_y (.val_i(cand_y_q), .val_o(clamp_y));

  always_comb begin
    dx      = (cx_q >= tx_q) ? (cx_q - tx_q) : (tx_q - cx_q);
    dy      = (cy_q >= ty_q) ? (cy_q - ty_q) : (ty_q - cy_q);
    overlap = (dx < X_W'(HIT_DIST)) && (dy < Y_W'(HIT_DIST));
    new_hit = overlap & ~prev_q;
  end

  // Commit registers load on the COLLIDE->COMMIT edge so they are valid alongside frame_valid.
  always_ff @(posedge clk_25mHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      se_q     <= 1'b0;
      btn_q    <= '0;
      ax_q     <= '0;
      ay_q     <= '0;
      tx_q     <= '0;
      ty_q     <= '0;
      cand_x_q <= '0;
      cand_y_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      px_q     <= X_W'(H_RES / 2);
      py_q     <= Y_W'(V_RES / 2);
      tcx_q    <= '0;
      tcy_q    <= '0;
      score_q  <= '0;
      prev_q   <= 1'b0;
      fv_q     <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      se_q    <= bus.screen_end;
      fv_q    <= 1'b0;
      hit_q   <= 1'b0;
      if (state_q == StSample) begin
        btn_q <= {bus.btn_d, bus.btn_r, bus.btn_l, bus.btn_u};
        ax_q  <= bus.accel_x;
        ay_q  <= bus.accel_y;
        tx_q  <= bus.target_x[X_W-1:0];
        ty_q  <= bus.target_y[Y_W-1:0];
      end
      if (state_q == StMove) begin
        cand_x_q <= cand_x_d;
        cand_y_q <= cand_y_d;
      end
      if (state_q == StClamp) begin
        cx_q <= clamp_x;
        cy_q <= clamp_y;
      end
      if (state_q == StCollide) begin
        px_q   <= cx_q;
        py_q   <= cy_q;
        tcx_q  <= tx_q;
        tcy_q  <= ty_q;
        fv_q   <= 1'b1;
        hit_q  <= new_hit;
        prev_q <= overlap;
        if (new_hit && (score_q != '1)) score_q <= score_q + 1'b1;
      end
    end
  end

  assign bus.player_x    = px_q;
  assign bus.player_y    = py_q;
  assign bus.target_cx   = tcx_q;
  assign bus.target_cy   = tcy_q;
  assign bus.frame_valid = fv_q;
  assign bus.hit         = hit_q;
  assign bus.score       = score_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Scoreboard bench for frame_update_scheduler: random and directed frames against a
// behavioural game model; a separate monitor checks every committed frame.
module tb_frame_update_scheduler;

  logic clk;
  logic reset_n;

  frame_update_scheduler_if bus ();

  frame_update_scheduler dut (
    .clk_25mHz (clk),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    int px;
    int py;
    int tx;
    int ty;
    bit hit;
    int score;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  int   frames_exp = 0;
  int   frames_seen = 0;
  bit   last_hit;

  // Model state
  int m_px, m_py, m_score;
  bit m_prev;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_px = 320; m_py = 240; m_score = 0; m_prev = 0;
  endtask

  // btn = {d, r, l, u}
  task automatic model_frame(input bit [3:0] btn, input int ax, input int ay,
                             input logic [31:0] tx, input logic [31:0] ty, output exp_t e);
    int  nx, ny, tmx, tmy;
    bit  ov;
    if (btn != 4'b0) begin
      nx = m_px;
      ny = m_py;
      if (btn[1] && !btn[2]) nx -= 4;
      if (btn[2] && !btn[1]) nx += 4;
      if (btn[0] && !btn[3]) ny -= 4;
      if (btn[3] && !btn[0]) ny += 4;
    end else begin
`ifdef ACCEL_FILTER_EN
      nx = (m_px + clampi(ax, 25, 614)) / 2;
      ny = (m_py + clampi(ay, 25, 454)) / 2;
`else
      nx = ax;
      ny = ay;
`endif
    end
    nx  = clampi(nx, 25, 614);
    ny  = clampi(ny, 25, 454);
    tmx = int'(tx & 32'h3FF);
    tmy = int'(ty & 32'h1FF);
    ov  = (absi(nx - tmx) < 55) && (absi(ny - tmy) < 55);
    e.hit = ov && !m_prev;
    if (e.hit && m_score < 255) m_score++;
    m_prev = ov;
    m_px = nx;
    m_py = ny;
    e.px = nx; e.py = ny; e.tx = tmx; e.ty = tmy; e.score = m_score;
  endtask

  // Monitor: every committed frame is popped and compared
  always @(negedge clk) begin
    if (bus.hit && !bus.frame_valid) chk("hit_without_frame_valid", 1, 0);
    if (bus.frame_valid) begin
      frames_seen++;
      last_hit = bus.hit;
      if (sb_q.size() == 0) begin
        chk("unexpected_frame_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_player_x", bus.player_x, e.px);
        chk("sb_player_y", bus.player_y, e.py);
        chk("sb_target_cx", bus.target_cx, e.tx);
        chk("sb_target_cy", bus.target_cy, e.ty);
        chk("sb_hit", bus.hit, e.hit);
        chk("sb_score", bus.score, e.score);
      end
    end
  end

  // mode: 0 normal, 1 drop enable mid-sequence, 2 extra screen_end edge while busy
  task automatic frame(input bit [3:0] btn, input int ax, input int ay,
                       input logic [31:0] tx, input logic [31:0] ty, input int mode);
    exp_t e;
    bit   got = 0;
    int   lat = 0;
    @(negedge clk);
    {bus.btn_d, bus.btn_r, bus.btn_l, bus.btn_u} = btn;
    bus.accel_x = ax;
    bus.accel_y = ay;
    bus.target_x = tx;
    bus.target_y = ty;
    bus.screen_end = 1'b1;
    model_frame(btn, ax, ay, tx, ty, e);
    sb_q.push_back(e);
    frames_exp++;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) bus.screen_end = 1'b0;
      if (k == 2 && mode == 1) bus.enable = 1'b0;
      if (k == 2 && mode == 2) bus.screen_end = 1'b1;
      if (k == 3 && mode == 2) bus.screen_end = 1'b0;
      if (bus.frame_valid && !got) begin
        got = 1;
        lat = k;
      end
      if (got && !bus.busy) break;
    end
    if (!got) chk("frame_valid_timeout", 0, 1);
    else chk("frame_valid_latency", lat, 5);
    bus.enable = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit [3:0]    btn;
    int          ax, ay;
    logic [31:0] tx, ty;

    reset_n = 1'b0;
    bus.screen_end = 1'b0;
    bus.enable = 1'b1;
    {bus.btn_d, bus.btn_r, bus.btn_l, bus.btn_u} = 4'b0;
    bus.accel_x = 0; bus.accel_y = 0; bus.target_x = 0; bus.target_y = 0;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_player_x", bus.player_x, 320);
    chk("rst_player_y", bus.player_y, 240);
    chk("rst_target_cx", bus.target_cx, 0);
    chk("rst_target_cy", bus.target_cy, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_hit", bus.hit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_frame_valid", bus.frame_valid, 0);

    // Left edge clamp from x=27
    frame(4'b0000, 27, 240, 0, 0, 0);
    frame(4'b0010, 0, 0, 0, 0, 0);
`ifndef ACCEL_FILTER_EN
    chk("btn_l_clamp_x", bus.player_x, 25);
`endif
    // Accel beyond right edge and negative y
    frame(4'b0000, 700, 32'hFFFF_FFF0, 0, 0, 0);
`ifndef ACCEL_FILTER_EN
    chk("accel_clamp_x", bus.player_x, 614);
    chk("accel_clamp_y", bus.player_y, 25);
`endif
    // Overlap scoring, then held overlap
    frame(4'b0000, 150, 100, 100, 100, 0);
`ifndef ACCEL_FILTER_EN
    chk("first_overlap_hit", last_hit, 1);
    chk("first_overlap_score", bus.score, 1);
`endif
    frame(4'b0000, 150, 100, 100, 100, 0);
`ifndef ACCEL_FILTER_EN
    chk("held_overlap_hit", last_hit, 0);
    chk("held_overlap_score", bus.score, 1);
`endif
    // Conflicting u+d cancel, r moves
    frame(4'b0000, 320, 240, 0, 0, 0);
    frame(4'b1101, 0, 0, 0, 0, 0);
`ifndef ACCEL_FILTER_EN
    chk("btn_udr_x", bus.player_x, 324);
    chk("btn_udr_y", bus.player_y, 240);
`endif

    // Edge while busy is dropped
    frame(4'b0100, 0, 0, 0, 0, 2);
    idle(10);
    chk("busy_edge_dropped", frames_seen, frames_exp);

    // Disabled: edge ignored
    bus.enable = 1'b0;
    @(negedge clk) bus.screen_end = 1'b1;
    idle(2);
    bus.screen_end = 1'b0;
    idle(10);
    chk("disabled_no_frame", frames_seen, frames_exp);
    chk("disabled_busy", bus.busy, 0);
    bus.enable = 1'b1;

    // Enable falling mid-sequence still commits
    frame(4'b1000, 0, 0, 50, 60, 1);
    idle(4);
    chk("enable_drop_commits", frames_seen, frames_exp);

    // Random frames
    for (int i = 0; i < 200; i++) begin
      btn = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 7) == 0) begin
        ax = int'($urandom);
        ay = int'($urandom);
      end else begin
        ax = int'($urandom_range(0, 1000)) - 150;
        ay = int'($urandom_range(0, 800)) - 150;
      end
      tx = $urandom;
      ty = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        tx = (tx & ~32'h3FF) | (32'(m_px + int'($urandom_range(0, 120)) - 60) & 32'h3FF);
        ty = (ty & ~32'h1FF) | (32'(m_py + int'($urandom_range(0, 120)) - 60) & 32'h1FF);
      end
      frame(btn, ax, ay, tx, ty, 0);
    end

    // Drive score into saturation
    for (int i = 0; i < 260; i++) begin
      frame(4'b0000, 300, 300, 300, 300, 0);
      frame(4'b0000, 500, 300, 300, 300, 0);
    end
    chk("score_saturated", bus.score, 255);
    frame(4'b0000, 300, 300, 300, 300, 0);
    chk("score_stays_255", bus.score, 255);

    // Reset during MOVE
    frame(4'b0000, 500, 300, 300, 300, 0);
    @(negedge clk) bus.screen_end = 1'b1;
    @(negedge clk) bus.screen_end = 1'b0;
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("midrst_player_x", bus.player_x, 320);
    chk("midrst_player_y", bus.player_y, 240);
    chk("midrst_target_cx", bus.target_cx, 0);
    chk("midrst_score", bus.score, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_frame_valid", bus.frame_valid, 0);
    idle(2);
    reset_n = 1'b1;
    model_reset();
    idle(10);
    chk("midrst_no_commit", frames_seen, frames_exp);

    // Accel path from a fresh reset position
    frame(4'b0000, 100, 240, 0, 0, 0);
`ifdef ACCEL_FILTER_EN
    chk("accel_after_rst_x", bus.player_x, 210);
`else
    chk("accel_after_rst_x", bus.player_x, 100);
`endif

    idle(5);
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("frame_count", frames_seen, frames_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
